// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory bus arbiter: FSM states, owner encoding
// and default bus widths.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Only meaningful while the bus is busy; IDLE maps to OWN_I but acks are gated.
  function automatic owner_e owner_of(state_e s);
    return (s == BUSY_D) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter that flags a bus transaction which has been outstanding for
// TIMEOUT cycles; reusable by any bus master.
module bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory bus between the fetch port (I) and the
// load/store port (D); D has priority, bounded by an anti-starvation streak.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  state_e     state;
  owner_e     owner;
  logic [3:0] streak;
  logic       busy;
  logic       done;
  logic       wdog_expired;

  assign busy  = (state != IDLE);
  assign owner = owner_of(state);
  assign done  = busy && (m_ack || wdog_expired);

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!busy || done),
    .en     (busy),
    .expired(wdog_expired)
  );

  // Completion is reported in the same cycle as m_ack or the watchdog expiry.
  assign i_ack   = done && (owner == OWN_I);
  assign d_ack   = done && (owner == OWN_D);
  assign i_err   = i_ack && !m_ack;
  assign d_err   = d_ack && !m_ack;
  assign i_rdata = (i_ack && m_ack) ? m_rdata : '0;
  assign d_rdata = (d_ack && m_ack) ? m_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      streak  <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && (!i_req || streak < STREAK_MAX)) begin
            state   <= BUSY_D;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            // Count only D grants that actually made a waiting fetch wait.
            if (i_req) streak <= (streak == STREAK_MAX) ? streak : streak + 4'd1;
            else       streak <= '0;
          end else if (i_req) begin
            state   <= BUSY_I;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            streak  <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state <= IDLE;
            m_req <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, collision, starvation, timeout,
// reset mid-transaction and a pipelined fetch stream against a simple memory.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, i_err, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic        resp_ack  = 1'b0;
  logic        extra_ack = 1'b0;
  logic        hang      = 1'b0;
  int          mem_lat   = 0;
  int          mem_cnt   = 0;
  logic [31:0] mem_data  = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  assign m_ack   = resp_ack | extra_ack;
  assign m_rdata = mem_data;

  // Memory acks mem_lat cycles after the first cycle m_req is seen high.
  always @(posedge clk) begin
    #1;
    if (!m_req) begin
      mem_cnt  = 0;
      resp_ack = 1'b0;
    end else begin
      resp_ack = !hang && (mem_cnt == mem_lat);
      mem_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int budget, output logic ai, output logic ad, output int n);
    ai = 1'b0;
    ad = 1'b0;
    n  = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (i_ack || d_ack) begin
        ai = i_ack;
        ad = d_ack;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic ai, ad;
    int   n;
    string exp_seq;

    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_m_req", m_req, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_we_wdata", {m_we, m_wdata[30:0]}, 0);
    check("rst_acks", {i_ack, d_ack, i_err, d_err}, 0);
    check("rst_rdata", i_rdata | d_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch, memory acks 2 cycles after m_req; input change mid-BUSY ignored.
    mem_lat = 2; mem_data = 32'h0050_0093;
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    check("fetch_m_req_latency", m_req, 1);
    check("fetch_m_addr", m_addr, 32'h100);
    i_addr = 32'h999;
    wait_ack(20, ai, ad, n);
    check("fetch_ack_cycles", n, 2);
    check("fetch_ack_owner", {ai, ad}, 2'b10);
    check("fetch_m_addr_held", m_addr, 32'h100);
    check("fetch_m_we", m_we, 0);
    check("fetch_rdata", i_rdata, 32'h0050_0093);
    check("fetch_err", i_err, 0);
    i_req = 1'b0;
    @(negedge clk);
    check("fetch_m_req_drop", m_req, 0);
    check("fetch_ack_pulse", i_ack, 0);

    // Collision: D store wins, I follows at the next decision.
    mem_lat = 0; mem_data = 32'h1111_2222;
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    wait_ack(10, ai, ad, n);
    check("coll_d_cycles", n, 1);
    check("coll_d_first", {ai, ad}, 2'b01);
    check("coll_d_m_we", m_we, 1);
    check("coll_d_m_addr", m_addr, 32'h2000);
    check("coll_d_m_wdata", m_wdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    wait_ack(10, ai, ad, n);
    check("coll_i_cycles", n, 2);
    check("coll_i_second", {ai, ad}, 2'b10);
    check("coll_i_m_addr", m_addr, 32'h200);
    check("coll_i_m_we_wdata", {m_we, m_wdata[30:0]}, 0);
    check("coll_i_rdata", i_rdata, 32'h1111_2222);
    i_req = 1'b0;
    @(negedge clk);

    // Starvation: both requests held, grant order D,D,D,D,I repeating.
    exp_seq = "DDDDIDDDDI";
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
    for (int k = 0; k < 10; k++) begin
      wait_ack(10, ai, ad, n);
      check($sformatf("starve_%0d_cycles", k), n, (k == 0) ? 1 : 2);
      check($sformatf("starve_%0d_owner", k), {ai, ad},
            (exp_seq[k] == "I") ? 2'b10 : 2'b01);
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Timeout: load never acked, aborted in the 16th BUSY cycle; late ack ignored.
    hang = 1'b1; mem_data = 32'h1234_5678;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    wait_ack(40, ai, ad, n);
    check("tmo_cycles", n, 16);
    check("tmo_owner", {ai, ad}, 2'b01);
    check("tmo_err", d_err, 1);
    check("tmo_rdata", d_rdata, 0);
    check("tmo_m_addr", m_addr, 32'h3000);
    d_req = 1'b0;
    @(negedge clk);
    check("tmo_m_req_drop", m_req, 0);
    repeat (2) @(negedge clk);
    extra_ack = 1'b1;
    #1;
    check("tmo_late_ack", {i_ack, d_ack, i_err, d_err}, 0);
    @(negedge clk);
    extra_ack = 1'b0;
    hang = 1'b0;

    // Reset while BUSY_I: m_req drops at once, no ack; then a normal D grant.
    hang = 1'b1;
    i_req = 1'b1; i_addr = 32'h500;
    repeat (3) @(negedge clk);
    check("rstop_busy", m_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstop_m_req_async", m_req, 0);
    check("rstop_no_ack", {i_ack, d_ack}, 0);
    check("rstop_m_addr", m_addr, 0);
    i_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; hang = 1'b0; mem_lat = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h600; d_wdata = 32'h0BAD_F00D;
    wait_ack(10, ai, ad, n);
    check("rstop_d_cycles", n, 1);
    check("rstop_d_owner", {ai, ad}, 2'b01);
    check("rstop_d_m_addr", m_addr, 32'h600);
    check("rstop_d_m_wdata", m_wdata, 32'h0BAD_F00D);
    d_req = 1'b0;
    @(negedge clk);

    // Pipelined fetch stream, address replaced at each ack.
    i_req = 1'b1; i_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      mem_data = 32'hC0DE_0000 | 32'(k);
      wait_ack(10, ai, ad, n);
      check($sformatf("stream_%0d_cycles", k), n, (k == 0) ? 1 : 2);
      check($sformatf("stream_%0d_owner", k), {ai, ad}, 2'b10);
      check($sformatf("stream_%0d_m_addr", k), m_addr, 32'(4 * k));
      check($sformatf("stream_%0d_rdata", k), i_rdata, 32'hC0DE_0000 | 32'(k));
      i_addr = 32'(4 * (k + 1));
    end
    i_req = 1'b0;
    @(negedge clk);
    check("stream_idle", m_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
